hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_if.sv | 36 +++
 rtl/hazard_unit.sv | 131 +++++++++++++
 tb/tb_hazard_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: ID-stage hazard query bundle between the pipeline control and
// the hazard unit. The master side drives the decoded ID instruction and the
// branch outcome; the slave side (hazard_unit) returns stall/flush, the
// forwarding selects and the event counters.
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int CW     = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_rf_wen;
    logic              id_is_load;
    logic              br_taken;
    logic              stall;
    logic              flush;
    logic [3:0]        fwd_rs1_sel;
    logic [3:0]        fwd_rs2_sel;
    logic [CW-1:0]     stall_cnt;
    logic [CW-1:0]     flush_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load, br_taken,
        input  stall, flush, fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load, br_taken,
        output stall, flush, fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: tracks in-flight destination registers for DEPTH post-decode
// stages (entry 0 = EXE, entry DEPTH-1 = WB) and resolves read-after-write
// hazards of the instruction in ID, either by stalling or by forwarding.
// Build option: define HAZARD_FORWARD_EN to enable forwarding; otherwise any
// pending write to a source register stalls and the forward selects are 0.
module hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CW         = 32
) (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave hz
);
`ifdef HAZARD_FORWARD_EN
    localparam logic FWD_MODE = 1'b1;
`else
    localparam logic FWD_MODE = 1'b0;
`endif
    localparam logic [3:0] LOAD_IDX = 4'(LOAD_STAGE);

    logic [DEPTH-1:0]  sb_valid_r;
    logic [DEPTH-1:0]  sb_wen_r;
    logic [DEPTH-1:0]  sb_load_r;
    logic [REG_AW-1:0] sb_rd_r [DEPTH];
    logic [CW-1:0]     stall_cnt_r;
    logic [CW-1:0]     flush_cnt_r;

    logic       rs1_hit_s, rs2_hit_s;
    logic       rs1_load_s, rs2_load_s;
    logic [3:0] rs1_idx_s, rs2_idx_s;
    logic       rs1_block_s, rs2_block_s;
    logic       stall_s, flush_s, id_take_s;
    logic [3:0] fwd1_s, fwd2_s;

    // A source depends on an entry only if it really reads a non-x0 register
    // that a live, register-writing entry will produce.
    function automatic logic src_hits(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              valid,
        input logic              wen,
        input logic [REG_AW-1:0] rd
    );
        return used && valid && wen && (rd == src) && (src != {REG_AW{1'b0}});
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && (v != {CW{1'b1}})) ? v + CW'(1) : v;
    endfunction

    // Youngest-match search: scan oldest to youngest so the lowest index wins.
    always_comb begin
        rs1_hit_s  = 1'b0;
        rs1_idx_s  = 4'd0;
        rs1_load_s = 1'b0;
        rs2_hit_s  = 1'b0;
        rs2_idx_s  = 4'd0;
        rs2_load_s = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_hits(hz.id_rs1_used, hz.id_rs1_addr, sb_valid_r[k], sb_wen_r[k], sb_rd_r[k])) begin
                rs1_hit_s  = 1'b1;
                rs1_idx_s  = 4'(k);
                rs1_load_s = sb_load_r[k];
            end else begin
                rs1_hit_s  = rs1_hit_s;
            end
            if (src_hits(hz.id_rs2_used, hz.id_rs2_addr, sb_valid_r[k], sb_wen_r[k], sb_rd_r[k])) begin
                rs2_hit_s  = 1'b1;
                rs2_idx_s  = 4'(k);
                rs2_load_s = sb_load_r[k];
            end else begin
                rs2_hit_s  = rs2_hit_s;
            end
        end
    end

    // Hazard resolution: without forwarding every hit blocks; with forwarding
    // only a load whose data is not yet available blocks. A taken branch
    // overrides any stall since the ID instruction is being killed anyway.
    always_comb begin
        flush_s     = hz.br_taken;
        rs1_block_s = rs1_hit_s & (~FWD_MODE | (rs1_load_s & (rs1_idx_s < LOAD_IDX)));
        rs2_block_s = rs2_hit_s & (~FWD_MODE | (rs2_load_s & (rs2_idx_s < LOAD_IDX)));
        stall_s     = hz.id_valid & ~flush_s & (rs1_block_s | rs2_block_s);
        fwd1_s      = (FWD_MODE && rs1_hit_s) ? rs1_idx_s + 4'd1 : 4'd0;
        fwd2_s      = (FWD_MODE && rs2_hit_s) ? rs2_idx_s + 4'd1 : 4'd0;
        id_take_s   = hz.id_valid & ~stall_s & ~flush_s;
    end

    // Scoreboard shift: ID instruction (or a bubble) enters entry 0, oldest drops out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid_r <= {DEPTH{1'b0}};
            sb_wen_r   <= {DEPTH{1'b0}};
            sb_load_r  <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                sb_rd_r[k] <= {REG_AW{1'b0}};
            end
        end else begin
            sb_valid_r <= {sb_valid_r[DEPTH-2:0], id_take_s};
            sb_wen_r   <= {sb_wen_r[DEPTH-2:0], hz.id_rf_wen};
            sb_load_r  <= {sb_load_r[DEPTH-2:0], hz.id_is_load};
            sb_rd_r[0] <= hz.id_rd_addr;
            for (int k = 1; k < DEPTH; k++) begin
                sb_rd_r[k] <= sb_rd_r[k-1];
            end
        end
    end

    // Event counters for stalls and flushes, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CW{1'b0}};
            flush_cnt_r <= {CW{1'b0}};
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, stall_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_s);
        end
    end

    assign hz.stall       = stall_s;
    assign hz.flush       = flush_s;
    assign hz.fwd_rs1_sel = fwd1_s;
    assign hz.fwd_rs2_sel = fwd2_s;
    assign hz.stall_cnt   = stall_cnt_r;
    assign hz.flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors for hazard_unit (DEPTH=3, LOAD_STAGE=1,
// CW=4). Each stimulus cycle pushes its hand-computed expectation into a
// queue; a monitor on the falling edge pops and compares. Expected values
// follow the build mode selected by HAZARD_FORWARD_EN.
module tb_hazard_unit;
    logic clk;
    logic rst;

    hazard_if #(.REG_AW(5), .CW(4)) hif ();

    hazard_unit #(
        .REG_AW(5),
        .DEPTH(3),
        .LOAD_STAGE(1),
        .CW(4)
    ) dut (
        .clk(clk),
        .reset(rst),
        .hz(hif.slave)
    );

    typedef struct {
        string      nm;
        logic       es;
        logic       ef;
        logic [3:0] e1;
        logic [3:0] e2;
        logic       cf;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_sc  = 4'd0;
    logic [3:0] m_fc  = 4'd0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compare the outputs of the current cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, ".stall"}, 32'(hif.stall), 32'(e.es));
            chk({e.nm, ".flush"}, 32'(hif.flush), 32'(e.ef));
            chk({e.nm, ".stall_cnt"}, 32'(hif.stall_cnt), 32'(e.sc));
            chk({e.nm, ".flush_cnt"}, 32'(hif.flush_cnt), 32'(e.fc));
            if (e.cf) begin
                chk({e.nm, ".fwd1"}, 32'(hif.fwd_rs1_sel), 32'(e.e1));
                chk({e.nm, ".fwd2"}, 32'(hif.fwd_rs2_sel), 32'(e.e2));
            end
        end
    end

    // One cycle: drive ID inputs, queue the expectation, advance past the edge.
    task automatic step(input string nm, input int v, input int rs1, input int u1,
                        input int rs2, input int u2, input int rd, input int wen,
                        input int ld, input int br, input int es, input int e1, input int e2);
        exp_t e;
        hif.id_valid    = 1'(v);
        hif.id_rs1_addr = 5'(rs1);
        hif.id_rs1_used = 1'(u1);
        hif.id_rs2_addr = 5'(rs2);
        hif.id_rs2_used = 1'(u2);
        hif.id_rd_addr  = 5'(rd);
        hif.id_rf_wen   = 1'(wen);
        hif.id_is_load  = 1'(ld);
        hif.br_taken    = 1'(br);
        if (rst) begin
            m_sc = 4'd0;
            m_fc = 4'd0;
        end
        e.nm = nm;
        e.es = 1'(es);
        e.ef = 1'(br);
        e.e1 = 4'(e1);
        e.e2 = 4'(e2);
        e.cf = (es == 0) && (br == 0);
        e.sc = m_sc;
        e.fc = m_fc;
        q.push_back(e);
        if (!rst) begin
            if (es != 0 && m_sc != 4'hF) m_sc = m_sc + 4'd1;
            if (br != 0 && m_fc != 4'hF) m_fc = m_fc + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step("bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        hif.id_valid = 1'b0;
        hif.id_rs1_addr = 5'd0;
        hif.id_rs2_addr = 5'd0;
        hif.id_rs1_used = 1'b0;
        hif.id_rs2_used = 1'b0;
        hif.id_rd_addr = 5'd0;
        hif.id_rf_wen = 1'b0;
        hif.id_is_load = 1'b0;
        hif.br_taken = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: stall 0, flush follows br_taken, counters 0.
        step("reset_hold", 1, 5, 1, 5, 1, 6, 1, 0, 1, 0, 0, 0);
        rst = 1'b0;

        // ADD x5 then ADD x6,x5,x5.
        step("s1_add_x5", 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
        step("s1_fwd_exe", 1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 1, 1);
`else
        for (int i = 0; i < 3; i++) step("s1_stall", 1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0, 0);
        step("s1_go", 1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
`endif
        drain();

        // LW x5 then ADD x6,x5,x0.
        step("s2_lw_x5", 1, 1, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
        step("s2_load_use", 1, 5, 1, 0, 1, 6, 1, 0, 0, 1, 0, 0);
        step("s2_fwd_mem", 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 2, 0);
`else
        for (int i = 0; i < 3; i++) step("s2_stall", 1, 5, 1, 0, 1, 6, 1, 0, 0, 1, 0, 0);
        step("s2_go", 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0);
`endif
        drain();

        // ADD x5, LW x5, then reader of x5 on rs2: youngest (the load) decides.
        step("s3_add_x5", 1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        step("s3_lw_x5", 1, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
        step("s3_youngest_load", 1, 3, 1, 5, 1, 9, 1, 0, 0, 1, 0, 0);
        step("s3_fwd_mem", 1, 3, 1, 5, 1, 9, 1, 0, 0, 0, 0, 2);
`else
        for (int i = 0; i < 3; i++) step("s3_stall", 1, 3, 1, 5, 1, 9, 1, 0, 0, 1, 0, 0);
        step("s3_go", 1, 3, 1, 5, 1, 9, 1, 0, 0, 0, 0, 0);
`endif
        drain();

        // Writer of x0 followed by reader of x0: never a hazard.
        step("s4_wr_x0", 1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0);
        step("s4_rd_x0", 1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0);
        drain();

        // Source not actually read: no hazard.
        step("s5_add_x5", 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
        step("s5_unused", 1, 5, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0);
        drain();

        // Branch during a load-use stall: flush wins, entry 0 becomes a bubble.
        step("s6_lw_x5", 1, 1, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0);
        step("s6_flush", 1, 5, 1, 0, 1, 7, 1, 0, 1, 0, 0, 0);
        step("s6_after_flush", 1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0, 0);
        drain();

        // Back-to-back LW x5,(x5): repeated stalls drive the counter to saturation.
        for (int i = 0; i < 40; i++) begin
`ifdef HAZARD_FORWARD_EN
            step("s7_sat", 1, 5, 1, 0, 1, 5, 1, 1, 0, (i % 2 == 1) ? 1 : 0, (i == 0) ? 0 : 2, 0);
`else
            step("s7_sat", 1, 5, 1, 0, 1, 5, 1, 1, 0, (i % 4 != 0) ? 1 : 0, 0, 0);
`endif
        end

        // Reset pulse in the middle of a stall: hazards and counters are discarded.
        rst = 1'b1;
        step("rst_mid_stall", 1, 5, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0);
        rst = 1'b0;
        step("post_rst_go", 1, 5, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0);
        step("post_rst_stall", 1, 5, 1, 0, 1, 5, 1, 1, 0, 1, 0, 0);
`ifdef HAZARD_FORWARD_EN
        step("post_rst_fwd", 1, 5, 1, 0, 1, 5, 1, 1, 0, 0, 2, 0);
`else
        step("post_rst_stall2", 1, 5, 1, 0, 1, 5, 1, 1, 0, 1, 0, 0);
`endif
        drain();

        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
